// File: rtl/mult_div_unit_pkg.sv
// Shared md_op codes and state encoding for the
// E-stage multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } md_state_e;

  function automatic logic is_mul(
    input logic [2:0] op
  );
    return op == MD_MULT || op == MD_MULTU;
  endfunction

  function automatic logic is_div(
    input logic [2:0] op
  );
    return op == MD_DIV || op == MD_DIVU;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle mult/div with HI/LO registers; results
// land on the last busy edge from latched operands.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ?
    MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          load, done;

  logic          idle_start;
  assign idle_start = start && state_q == ST_IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_start && is_mul(md_op)) begin
          state_d = ST_RUN;
          cnt_d   = MUL_N;
          load    = 1'b1;
        end else if (idle_start && is_div(md_op)) begin
          state_d = ST_RUN;
          cnt_d   = DIV_N;
          load    = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        op_q <= md_op;
        a_q  <= A;
        b_q  <= B;
      end
    end
  end

  assign busy = (state_q == ST_RUN);

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, den;
  logic [31:0] q_u, r_u, q_s, r_s;
  logic        sgn_div;

  assign prod_s = {{32{a_q[31]}}, a_q}
                * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes so INT_MIN / -1
  // wraps to INT_MIN with no special case.
  assign sgn_div = (op_q == MD_DIV);
  assign abs_a = (sgn_div && a_q[31]) ? -a_q : a_q;
  assign abs_b = (sgn_div && b_q[31]) ? -b_q : b_q;
  assign den   = (b_q == '0) ? 32'd1 : abs_b;
  assign q_u   = abs_a / den;
  assign r_u   = abs_a % den;
  assign q_s   = (sgn_div && (a_q[31] ^ b_q[31]))
               ? -q_u : q_u;
  assign r_s   = (sgn_div && a_q[31]) ? -r_u : r_u;

  logic        wr_hi, wr_lo;
  logic [31:0] hi_d, lo_d;

  always_comb begin
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    hi_d  = HI;
    lo_d  = LO;
    unique case (1'b1)
      done && op_q == MD_MULT: begin
        {wr_hi, wr_lo} = 2'b11;
        {hi_d, lo_d}   = prod_s;
      end
      done && op_q == MD_MULTU: begin
        {wr_hi, wr_lo} = 2'b11;
        {hi_d, lo_d}   = prod_u;
      end
      done && is_div(op_q) && b_q != '0: begin
        {wr_hi, wr_lo} = 2'b11;
        hi_d = r_s;
        lo_d = q_s;
      end
      idle_start && md_op == MD_MTHI: begin
        wr_hi = 1'b1;
        hi_d  = A;
      end
      idle_start && md_op == MD_MTLO: begin
        wr_lo = 1'b1;
        lo_d  = A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else begin
      if (wr_hi) HI <= hi_d;
      if (wr_lo) LO <= lo_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Random and directed checks of mult_div_unit against
// a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A(A),
    .B(B),
    .busy(busy),
    .HI(HI),
    .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return MC;
    if (op == 3'd3 || op == 3'd4) return DC;
    return 0;
  endfunction

  task automatic model(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    longint          sa, sb, q, r;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin
        q = sa * sb;
        m_hi = q[63:32];
        m_lo = q[31:0];
      end
      3'd2: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      3'd3: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      3'd4: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one op at a negedge; ends at the negedge
  // after the result edge. inj pokes a start mid-busy.
  task automatic run_op(
    input string       tag,
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          inj
  );
    int          n;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1;
    md_op = op;
    A = a;
    B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A = $urandom;
    B = $urandom;
    n = 0;
    if (lat(op) > 0) begin
      chk({tag, "_hold_hi"}, 64'(HI), 64'(old_hi));
      chk({tag, "_hold_lo"}, 64'(LO), 64'(old_lo));
    end
    while (busy && n < 100) begin
      n++;
      start = 1'b0;
      if (inj && n == 2) begin
        start = 1'b1;
        md_op = 3'(1 + $urandom_range(0, 5));
        A = $urandom;
        B = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
    model(op, a, b);
    chk({tag, "_busy_len"}, 64'(n), 64'(lat(op)));
    chk({tag, "_hi"}, 64'(HI), 64'(m_hi));
    chk({tag, "_lo"}, 64'(LO), 64'(m_lo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(HI), 64'(0));
    chk("rst_lo", 64'(LO), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 0);
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0);
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 0);
    run_op("divu0", 3'd4, 32'd7, 32'd0, 0);
    run_op("mthi", 3'd5, 32'h12345678, 32'd0, 0);
    run_op("mtlo", 3'd6, 32'h9ABCDEF0, 32'd0, 0);
    run_op("ovf", 3'd3, 32'h80000000,
           32'hFFFFFFFF, 0);
    run_op("none", 3'd0, 32'h55, 32'h66, 0);
    run_op("undef", 3'd7, 32'h55, 32'h66, 0);
    run_op("inj", 3'd1, 32'h00012345,
           32'hFFFF0003, 1);

    // Async reset in the middle of a divide
    run_op("mthi2", 3'd5, 32'hCAFE0001, 32'd0, 0);
    start = 1'b1;
    md_op = 3'd3;
    A = 32'd100;
    B = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_hi", 64'(HI), 64'(0));
    chk("arst_lo", 64'(LO), 64'(0));
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("stale_busy", 64'(busy), 64'(0));
    chk("stale_hi", 64'(HI), 64'(0));
    chk("stale_lo", 64'(LO), 64'(0));

    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: ra = 32'h80000000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op("rand", rop, ra, rb,
             bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
